mem_port_arbiter: RTL and testbench

//  Shares the CPU's single-ported unified memory (text at 0x0000, data at 0x2000)

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// No logic here: FSM state type and grant identifiers only.
// Imported by the arbiter top and its winner-pick sub-module.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_IF   = 2'd0;
    localparam logic [1:0] GNT_DM   = 2'd1;
    localparam logic [1:0] GNT_DBG  = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;

endpackage

// File: rtl/mem_arb_pick.sv
// Picks the next memory owner from the three request lines.
// Purely combinational, zero latency.
// No flow control of its own; the caller samples it only when idle.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       starve,
    output logic [1:0] winner
);

    // DBG > DM > IF, except a starved IF jumps ahead of DM (never ahead of DBG)
    always_comb begin
        winner = GNT_NONE;
        if (dbg_req) begin
            winner = GNT_DBG;
        end else if (starve && if_req) begin
            winner = GNT_IF;
        end else if (dm_req) begin
            winner = GNT_DM;
        end else if (if_req) begin
            winner = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF / DM / DBG accesses onto one single-ported memory.
// Request sampled in IDLE at edge k: mem_en in cycle k+1, ack in cycle k+MEM_LAT+2.
// Requesters hold req until their one-cycle ack; one access per MEM_LAT+3 cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant_id
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

    arb_state_t        state_q,     state_d;
    logic [1:0]        grant_q,     grant_d;
    logic [LAT_W-1:0]  lat_q,       lat_d;
    logic [STV_W-1:0]  stv_q,       stv_d;
    logic              acc_we_q,    acc_we_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              dm_ack_q,    dm_ack_d;
    logic              dbg_ack_q,   dbg_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [1:0]        winner;

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .dm_req  (dm_req),
        .dbg_req (dbg_req),
        .starve  (stv_q == STV_MAX),
        .winner  (winner)
    );

    // Next-state: arbitrate in IDLE, strobe once, count out the latency, ack the winner
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lat_d       = lat_q;
        stv_d       = stv_q;
        acc_we_d    = acc_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        dbg_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    stv_d = '0;
                end
                if (winner != GNT_NONE) begin
                    state_d  = ST_ISSUE;
                    grant_d  = winner;
                    mem_en_d = 1'b1;
                    case (winner)
                        GNT_DBG: begin
                            acc_we_d    = dbg_we;
                            mem_addr_d  = dbg_addr;
                            mem_wdata_d = dbg_wdata;
                        end
                        GNT_DM: begin
                            acc_we_d    = dm_we;
                            mem_addr_d  = dm_addr;
                            mem_wdata_d = dm_wdata;
                        end
                        default: begin
                            acc_we_d    = 1'b0;
                            mem_addr_d  = if_addr;
                            mem_wdata_d = '0;
                        end
                    endcase
                    mem_we_d = acc_we_d;
                    // Starve count tracks DM wins that left a waiting IF behind
                    if (winner == GNT_IF) begin
                        stv_d = '0;
                    end else if (winner == GNT_DM && if_req && stv_q != STV_MAX) begin
                        stv_d = stv_q + STV_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                lat_d   = LAT_LAST;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_RESP;
                    case (grant_q)
                        GNT_IF: begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                        GNT_DM: begin
                            dm_ack_d   = 1'b1;
                            dm_rdata_d = acc_we_q ? '0 : mem_rdata;
                        end
                        GNT_DBG: begin
                            dbg_ack_d   = 1'b1;
                            dbg_rdata_d = acc_we_q ? '0 : mem_rdata;
                        end
                        default: ;
                    endcase
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            lat_q       <= '0;
            stv_q       <= '0;
            acc_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lat_q       <= lat_d;
            stv_q       <= stv_d;
            acc_we_q    <= acc_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT=3, STARVE_LIM=4.
// Directed steps first, then a randomized run against a transaction-level model.
// Requester index: 0=IF, 1=DM, 2=DBG (matches grant_id).
module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int SLIM = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        r_req  [3];
    logic        r_we   [3];
    logic [31:0] r_addr [3];
    logic [31:0] r_wd   [3];
    logic [2:0]  ack;
    logic [31:0] rdata  [3];
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant_id;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] dev_mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] pipe    [LAT+1];

    // transaction-level model state
    int          e, k, next_arb, scnt, ngr, w, cyc;
    int          gap [3];
    logic        g_we, prev_en;
    logic [31:0] g_addr, g_wd, g_rd, v;
    logic [1:0]  seq [$];
    logic [1:0]  last;
    logic [1:0]  exp4 [6];
    logic [1:0]  exp5 [6];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (r_req[0]),
        .if_addr   (r_addr[0]),
        .if_rdata  (rdata[0]),
        .if_ack    (ack[0]),
        .dm_req    (r_req[1]),
        .dm_we     (r_we[1]),
        .dm_addr   (r_addr[1]),
        .dm_wdata  (r_wd[1]),
        .dm_rdata  (rdata[1]),
        .dm_ack    (ack[1]),
        .dbg_req   (r_req[2]),
        .dbg_we    (r_we[2]),
        .dbg_addr  (r_addr[2]),
        .dbg_wdata (r_wd[2]),
        .dbg_rdata (rdata[2]),
        .dbg_ack   (ack[2]),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id)
    );

    function automatic int idx(input logic [31:0] a);
        return int'({a[13], a[4:2]});
    endfunction

    function automatic logic [31:0] rand_addr(input bit text_only);
        logic [31:0] base;
        base = (text_only || $urandom_range(0, 1) == 0) ? 32'h0000 : 32'h2000;
        return base + 32'($urandom_range(0, 7) << 2);
    endfunction

    function automatic logic [2:0] own(input logic [1:0] g);
        return (g == 2'd3) ? 3'b000 : (3'b001 << g);
    endfunction

    // Memory device: access on the strobe cycle, data valid LAT cycles later, junk otherwise
    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = $urandom;
        if (mem_en === 1'b1) begin
            if (mem_we) dev_mem[idx(mem_addr)] = mem_wdata;
            else        pipe[0] = dev_mem[idx(mem_addr)];
        end
        mem_rdata = pipe[LAT];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        r_req[p]  = 1'b1;
        r_we[p]   = we;
        r_addr[p] = a;
        r_wd[p]   = d;
    endtask

    // One isolated access from requester p; fields are scrambled right after the strobe
    task automatic do_access(input int p, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd, input bit early);
        set_req(p, we, a, d);
        for (int c = 1; c <= LAT + 3; c++) begin
            tick();
            check($sformatf("p%0d mem_en c%0d", p, c), mem_en, (c == 1));
            if (c == 1) begin
                check($sformatf("p%0d mem_we", p), mem_we, we);
                check($sformatf("p%0d mem_addr", p), mem_addr, a);
                if (we) check($sformatf("p%0d mem_wdata", p), mem_wdata, d);
                if (early) r_req[p] = 1'b0;
                r_addr[p] = ~a;
                r_wd[p]   = ~d;
            end
            check($sformatf("p%0d acks c%0d", p, c), ack, (c == LAT + 2) ? (3'b001 << p) : 3'b000);
            check($sformatf("p%0d grant c%0d", p, c), grant_id, (c <= LAT + 2) ? p : 3);
            if (c == LAT + 2) begin
                check($sformatf("p%0d rdata", p), rdata[p], exp_rd);
                r_req[p] = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0; gap[i] = 0;
        end
        for (int i = 0; i < 16; i++) dev_mem[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i <= LAT; i++) pipe[i] = '0;
        dev_mem[idx(32'h0)] = 32'h2008_0005;
        exp4 = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd3};
        exp5 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst acks", ack, 3'b000);
        check("rst mem_en", mem_en, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst grant", grant_id, 2'd3);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        for (int i = 0; i < 3; i++) check($sformatf("rst rdata%0d", i), rdata[i], 32'h0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of WAIT: everything drops at once, no late ack
        set_req(0, 1'b0, 32'h4, 32'h0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst acks", ack, 3'b000);
        check("midrst mem_en", mem_en, 1'b0);
        check("midrst grant", grant_id, 2'd3);
        r_req[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 4; c++) begin
            tick();
            check("postrst acks", ack, 3'b000);
            check("postrst mem_en", mem_en, 1'b0);
        end

        // IF read of address 0
        do_access(0, 1'b0, 32'h0, 32'h0, 32'h2008_0005, 1'b0);
        // DM write then read back
        do_access(1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_access(1, 1'b0, 32'h2000, 32'h0, 32'hDEAD_BEEF, 1'b0);
        // DBG read that drops req right after the strobe still completes
        do_access(2, 1'b0, 32'h2000, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // All three at once: DBG, then DM, then IF
        set_req(0, 1'b0, 32'h8, 32'h0);
        set_req(1, 1'b0, 32'h2004, 32'h0);
        set_req(2, 1'b0, 32'h2008, 32'h0);
        seq.delete();
        last = 2'd3;
        for (int c = 0; c < 8 * (LAT + 3) && seq.size() < 6; c++) begin
            tick();
            check("prio ack owner", ack & ~own(grant_id), 3'b000);
            if (grant_id !== last) begin
                seq.push_back(grant_id);
                last = grant_id;
            end
            for (int q = 0; q < 3; q++) if (ack[q]) r_req[q] = 1'b0;
        end
        check("prio count", seq.size(), 6);
        while (seq.size() < 6) seq.push_back(2'bxx);
        for (int i = 0; i < 6; i++) check($sformatf("prio grant[%0d]", i), seq[i], exp4[i]);
        for (int q = 0; q < 3; q++) r_req[q] = 1'b0;
        repeat (LAT + 4) tick();

        // Starvation: DM held forever, IF waiting -> 4 DM, 1 IF, DM again
        set_req(0, 1'b0, 32'hC, 32'h0);
        set_req(1, 1'b0, 32'h200C, 32'h0);
        seq.delete();
        last = 2'd3;
        for (int c = 0; c < 10 * (LAT + 3) && seq.size() < 6; c++) begin
            tick();
            if (grant_id !== last && grant_id !== 2'd3) seq.push_back(grant_id);
            last = grant_id;
            if (ack[0]) r_req[0] = 1'b0;
        end
        check("starve count", seq.size(), 6);
        while (seq.size() < 6) seq.push_back(2'bxx);
        for (int i = 0; i < 6; i++) check($sformatf("starve grant[%0d]", i), seq[i], exp5[i]);
        for (int q = 0; q < 3; q++) r_req[q] = 1'b0;
        repeat (LAT + 4) tick();

        // Randomized run against the transaction-level model
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        e = 0; k = -1000; next_arb = 0; scnt = 0; ngr = 0; w = 0; cyc = 0;
        g_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0; prev_en = 1'b0;
        while (cyc < 20000 && !(ngr >= 1000 && e > k + LAT + 2)) begin
            @(posedge clk);
            // arbitration point: the arbiter is free from next_arb on
            if (e >= next_arb) begin
                if (!r_req[0]) scnt = 0;
                if (r_req[0] || r_req[1] || r_req[2]) begin
                    if (r_req[2])                     w = 2;
                    else if (scnt >= SLIM && r_req[0]) w = 0;
                    else if (r_req[1])                 w = 1;
                    else                               w = 0;
                    if (w == 0) scnt = 0;
                    else if (w == 1 && r_req[0] && scnt < SLIM) scnt = scnt + 1;
                    g_we   = (w == 0) ? 1'b0 : r_we[w];
                    g_addr = r_addr[w];
                    g_wd   = r_wd[w];
                    g_rd   = g_we ? 32'h0 : ref_mem[idx(g_addr)];
                    if (g_we) ref_mem[idx(g_addr)] = g_wd;
                    k = e;
                    next_arb = e + LAT + 3;
                    ngr++;
                end
            end
            #1;
            check("rnd mem_en", mem_en, (e == k));
            check("rnd mem_en b2b", mem_en & prev_en, 1'b0);
            prev_en = mem_en;
            if (e == k) begin
                check("rnd mem_we", mem_we, g_we);
                check("rnd mem_addr", mem_addr, g_addr);
                if (g_we) check("rnd mem_wdata", mem_wdata, g_wd);
            end
            check("rnd acks", ack, (e == k + LAT + 1) ? (3'b001 << w) : 3'b000);
            if (e == k + LAT + 1) check("rnd rdata", rdata[w], g_rd);
            check("rnd grant", grant_id, (e >= k && e <= k + LAT + 1) ? w : 3);
            // requesters: drop on ack, pause, then maybe issue a fresh random request
            for (int p = 0; p < 3; p++) begin
                if (ack[p]) begin
                    r_req[p] = 1'b0;
                    gap[p]   = $urandom_range(0, 2);
                end else if (r_req[p]) begin
                    if (p == w && e > k && e < k + LAT + 1 && $urandom_range(0, 3) == 0) begin
                        r_addr[p] = rand_addr(1'b0);
                        r_wd[p]   = $urandom;
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if (ngr < 1000 && $urandom_range(0, 2) == 0) begin
                    set_req(p, (p == 0) ? 1'b0 : 1'($urandom_range(0, 1)), rand_addr(p == 0), $urandom);
                end
            end
            e++;
            cyc++;
        end
        check("rnd grants done", (ngr >= 1000), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
